// File: rtl/controle_catraca.sv
// rtl/controle_catraca.sv - turnstile access scheduler with occupancy count and metal alarm
module controle_catraca #(
  parameter int TIMEOUT_CICLOS = 50,
  parameter int LOTACAO_MAX    = 9
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_entrada,
  input  logic       req_saida,
  input  logic       giro,
  input  logic       metais,
  input  logic       ack_alarme,
  output logic       grant_entrada,
  output logic       grant_saida,
  output logic       violacao,
  output logic [3:0] ocupacao,
  output logic [1:0] ledVerde,
  output logic [1:0] ledVermelho,
  output logic [6:0] display
);

  typedef enum logic [1:0] {LIVRE, CONCEDE_E, CONCEDE_S, ALARME} estado_t;

  // ultimo remembers which side was served last so ties alternate
  localparam logic ENTRADA = 1'b0;
  localparam logic SAIDA   = 1'b1;

  localparam int             TW       = $clog2(TIMEOUT_CICLOS + 1);
  localparam logic [TW-1:0]  T_ULTIMO = TW'(TIMEOUT_CICLOS - 1);
  localparam logic [3:0]     MAX_OC   = 4'(LOTACAO_MAX);

  estado_t       state_q, state_d;
  logic [3:0]    ocupacao_q, ocupacao_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          giro_q, giro_d;
  logic          ultimo_q, ultimo_d;
  logic          violacao_q, violacao_d;

  logic rot;
  logic ent_ok;
  logic sai_ok;

  assign rot    = giro & ~giro_q;
  assign ent_ok = req_entrada & ~metais & (ocupacao_q < MAX_OC);
  assign sai_ok = req_saida & (ocupacao_q > 4'd0);

  // next-state, occupancy, grant timer and violation pulse
  always_comb begin
    state_d    = state_q;
    ocupacao_d = ocupacao_q;
    timer_d    = '0;
    ultimo_d   = ultimo_q;
    violacao_d = 1'b0;
    giro_d     = giro;
    case (state_q)
      LIVRE: begin
        violacao_d = rot;
        if (req_entrada && metais) begin
          state_d = ALARME;
        end else if (ent_ok && sai_ok) begin
          state_d = (ultimo_q == SAIDA) ? CONCEDE_E : CONCEDE_S;
        end else if (ent_ok) begin
          state_d = CONCEDE_E;
        end else if (sai_ok) begin
          state_d = CONCEDE_S;
        end
      end
      CONCEDE_E: begin
        if (metais) begin
          state_d = ALARME;
        end else if (rot) begin
          if (ocupacao_q < MAX_OC) ocupacao_d = ocupacao_q + 4'd1;
          ultimo_d = ENTRADA;
          state_d  = LIVRE;
        end else if (timer_q == T_ULTIMO) begin
          ultimo_d = ENTRADA;
          state_d  = LIVRE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      CONCEDE_S: begin
        if (rot) begin
          if (ocupacao_q > 4'd0) ocupacao_d = ocupacao_q - 4'd1;
          ultimo_d = SAIDA;
          state_d  = LIVRE;
        end else if (timer_q == T_ULTIMO) begin
          ultimo_d = SAIDA;
          state_d  = LIVRE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ALARME: begin
        violacao_d = rot;
        if (ack_alarme && !metais) state_d = LIVRE;
      end
      default: state_d = LIVRE;
    endcase
  end

  // state register with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= LIVRE;
      ocupacao_q <= 4'd0;
      timer_q    <= '0;
      giro_q     <= 1'b0;
      ultimo_q   <= SAIDA;
      violacao_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ocupacao_q <= ocupacao_d;
      timer_q    <= timer_d;
      giro_q     <= giro_d;
      ultimo_q   <= ultimo_d;
      violacao_q <= violacao_d;
    end
  end

  // active-low 7-segment decode {g,f,e,d,c,b,a} of the registered count
  always_comb begin
    display = 7'b0111111;
    case (ocupacao_q)
      4'd0: display = 7'b1000000;
      4'd1: display = 7'b1111001;
      4'd2: display = 7'b0100100;
      4'd3: display = 7'b0110000;
      4'd4: display = 7'b0011001;
      4'd5: display = 7'b0010010;
      4'd6: display = 7'b0000010;
      4'd7: display = 7'b1111000;
      4'd8: display = 7'b0000000;
      4'd9: display = 7'b0010000;
      default: display = 7'b0111111;
    endcase
  end

  assign grant_entrada = (state_q == CONCEDE_E);
  assign grant_saida   = (state_q == CONCEDE_S);
  assign violacao      = violacao_q;
  assign ocupacao      = ocupacao_q;
  assign ledVerde      = {grant_saida, grant_entrada};
  assign ledVermelho   = {(state_q == ALARME), (ocupacao_q == MAX_OC)};

endmodule

// File: tb/tb_controle_catraca.sv
// tb/tb_controle_catraca.sv - scoreboard bench for controle_catraca
module tb_controle_catraca;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       req_entrada = 1'b0;
  logic       req_saida = 1'b0;
  logic       giro = 1'b0;
  logic       metais = 1'b0;
  logic       ack_alarme = 1'b0;
  logic       grant_entrada;
  logic       grant_saida;
  logic       violacao;
  logic [3:0] ocupacao;
  logic [1:0] ledVerde;
  logic [1:0] ledVermelho;
  logic [6:0] display;

  controle_catraca #(.TIMEOUT_CICLOS(50), .LOTACAO_MAX(9)) dut (
    .clock(clock),
    .reset(reset),
    .req_entrada(req_entrada),
    .req_saida(req_saida),
    .giro(giro),
    .metais(metais),
    .ack_alarme(ack_alarme),
    .grant_entrada(grant_entrada),
    .grant_saida(grant_saida),
    .violacao(violacao),
    .ocupacao(ocupacao),
    .ledVerde(ledVerde),
    .ledVermelho(ledVermelho),
    .display(display)
  );

  always #5 clock = ~clock;

  // expected output snapshot; dur is how long the previous snapshot must have lasted (0 = any)
  typedef struct {
    string       name;
    logic [17:0] v;
    int          dur;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 1'b0;
  logic [17:0] prev_v = 'x;
  int          stable = 0;

  wire [17:0] dut_v = {grant_entrada, grant_saida, violacao, ocupacao, ledVerde, ledVermelho, display};

  function automatic logic [6:0] seg(input int n);
    case (n)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  function automatic logic [17:0] mk(input logic ge, input logic gs, input logic vi, input int oc, input logic al);
    logic full;
    full = (oc == 9);
    return {ge, gs, vi, 4'(oc), gs, ge, al, full, seg(oc)};
  endfunction

  task automatic push(input string n, input logic ge, input logic gs, input logic vi,
                      input int oc, input logic al, input int dur);
    exp_t e;
    e.name = n;
    e.v    = mk(ge, gs, vi, oc, al);
    e.dur  = dur;
    sb.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // monitor: every change of the output vector consumes one expected snapshot
  always @(negedge clock) begin
    if (mon_en) begin
      if (dut_v !== prev_v) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change got %b required no change", dut_v);
        end else begin
          mon_e = sb.pop_front();
          if (dut_v !== mon_e.v) begin
            errors++;
            $display("FAIL %s got %b required %b (ge gs vi ocup ledVerde ledVermelho display)",
                     mon_e.name, dut_v, mon_e.v);
          end
          if (mon_e.dur != 0) begin
            checks++;
            if (stable != mon_e.dur) begin
              errors++;
              $display("FAIL %s_duration got %0d required %0d", mon_e.name, stable, mon_e.dur);
            end
          end
        end
        prev_v = dut_v;
        stable = 1;
      end else begin
        stable++;
      end
    end
  end

  initial begin
    step(2);
    push("reset", 0, 0, 0, 0, 0, 0);
    reset  = 1'b0;
    mon_en = 1'b1;

    // single entry with a passage three cycles later
    push("t1_grant", 1, 0, 0, 0, 0, 0);
    req_entrada = 1'b1;
    step(1);
    req_entrada = 1'b0;
    step(2);
    giro = 1'b1;
    push("t1_count", 0, 0, 0, 1, 0, 3);
    step(1);
    giro = 1'b0;

    // second entry, then alternating ties with ultimo=ENTRADA
    push("t2_grant_e", 1, 0, 0, 1, 0, 0);
    req_entrada = 1'b1;
    step(1);
    req_entrada = 1'b0;
    giro = 1'b1;
    push("t2_fill", 0, 0, 0, 2, 0, 1);
    step(1);
    giro = 1'b0;
    req_entrada = 1'b1;
    req_saida = 1'b1;
    push("alt_s1", 0, 1, 0, 2, 0, 0);
    step(1);
    giro = 1'b1;
    push("alt_s1_done", 0, 0, 0, 1, 0, 1);
    step(1);
    giro = 1'b0;
    push("alt_e", 1, 0, 0, 1, 0, 0);
    step(1);
    giro = 1'b1;
    push("alt_e_done", 0, 0, 0, 2, 0, 1);
    step(1);
    giro = 1'b0;
    push("alt_s2", 0, 1, 0, 2, 0, 0);
    step(1);
    giro = 1'b1;
    push("alt_s2_done", 0, 0, 0, 1, 0, 1);
    step(1);
    giro = 1'b0;
    req_entrada = 1'b0;
    req_saida = 1'b0;

    // entry grant that expires without rotation
    push("to_grant", 1, 0, 0, 1, 0, 0);
    req_entrada = 1'b1;
    step(1);
    req_entrada = 1'b0;
    push("to_expire", 0, 0, 0, 1, 0, 50);
    step(51);

    // metal detector and rotation in the same cycle during an entry grant
    push("md_grant", 1, 0, 0, 1, 0, 0);
    req_entrada = 1'b1;
    step(1);
    req_entrada = 1'b0;
    metais = 1'b1;
    giro = 1'b1;
    push("md_alarm", 0, 0, 0, 1, 1, 0);
    step(1);
    ack_alarme = 1'b1;
    step(2);
    metais = 1'b0;
    push("md_clear", 0, 0, 0, 1, 0, 3);
    step(1);
    ack_alarme = 1'b0;
    giro = 1'b0;

    // entry request with metal from LIVRE, rotation while alarmed
    req_entrada = 1'b1;
    metais = 1'b1;
    push("lv_alarm", 0, 0, 0, 1, 1, 0);
    step(1);
    req_entrada = 1'b0;
    giro = 1'b1;
    push("alarm_viol", 0, 0, 1, 1, 1, 0);
    step(1);
    giro = 1'b0;
    push("alarm_viol_end", 0, 0, 0, 1, 1, 1);
    step(1);
    metais = 1'b0;
    ack_alarme = 1'b1;
    push("lv_clear", 0, 0, 0, 1, 0, 0);
    step(1);
    ack_alarme = 1'b0;

    // fill the room up to capacity
    for (int k = 1; k <= 8; k++) begin
      push("fill_grant", 1, 0, 0, k, 0, 0);
      req_entrada = 1'b1;
      step(1);
      req_entrada = 1'b0;
      giro = 1'b1;
      push("fill_count", 0, 0, 0, k + 1, 0, 1);
      step(1);
      giro = 1'b0;
    end

    // full room refuses entry (no output change expected)
    req_entrada = 1'b1;
    step(3);
    req_entrada = 1'b0;

    // exit grant interrupted by reset
    push("full_exit_grant", 0, 1, 0, 9, 0, 0);
    req_saida = 1'b1;
    step(1);
    req_saida = 1'b0;
    step(2);
    reset = 1'b1;
    push("reset_mid", 0, 0, 0, 0, 0, 3);
    step(1);
    reset = 1'b0;

    // empty room refuses exit (no output change expected)
    req_saida = 1'b1;
    step(3);
    req_saida = 1'b0;

    // rotation while idle
    giro = 1'b1;
    push("idle_viol", 0, 0, 1, 0, 0, 0);
    step(1);
    giro = 1'b0;
    push("idle_viol_end", 0, 0, 0, 0, 0, 1);
    step(4);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL pending_expectations got %0d required 0 (next %s)", sb.size(), sb[0].name);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
